// File: rtl/s4_feature_buffer.sv
// s4_feature_buffer: ping-pong S4 frame buffer replaying pooled C3 frames to C5 over valid/ready
module s4_feature_buffer #(
    parameter int DEPTH = 25,
    parameter int OVF_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c3_mp_out_valid,
    input  logic [7:0]       c3_mp_out_ch_0,
    input  logic [7:0]       c3_mp_out_ch_1,
    input  logic [7:0]       c3_mp_out_ch_2,
    input  logic [7:0]       c3_mp_out_ch_3,
    input  logic [7:0]       c3_mp_out_ch_4,
    input  logic [7:0]       c3_mp_out_ch_5,
    input  logic [7:0]       c3_mp_out_ch_6,
    input  logic [7:0]       c3_mp_out_ch_7,
    input  logic [7:0]       c3_mp_out_ch_8,
    input  logic [7:0]       c3_mp_out_ch_9,
    input  logic [7:0]       c3_mp_out_ch_10,
    input  logic [7:0]       c3_mp_out_ch_11,
    input  logic [7:0]       c3_mp_out_ch_12,
    input  logic [7:0]       c3_mp_out_ch_13,
    input  logic [7:0]       c3_mp_out_ch_14,
    input  logic [7:0]       c3_mp_out_ch_15,
    output logic             s4_valid,
    input  logic             s4_ready,
    output logic [127:0]     s4_data,
    output logic [4:0]       s4_pos,
    output logic             s4_last,
    output logic             s4_frame_done,
    output logic [OVF_W-1:0] s4_overflow_cnt
);
    localparam logic [4:0] LAST = 5'(DEPTH - 1);
    logic [127:0] mem [2][DEPTH];
    logic [127:0] beat;
    logic [1:0]   full;
    logic         wr_bank, rd_bank;
    logic [4:0]   wr_ptr, rd_ptr;
    logic         wr_en, drop, ld, hs;
    assign beat = {c3_mp_out_ch_15, c3_mp_out_ch_14, c3_mp_out_ch_13, c3_mp_out_ch_12,
                   c3_mp_out_ch_11, c3_mp_out_ch_10, c3_mp_out_ch_9,  c3_mp_out_ch_8,
                   c3_mp_out_ch_7,  c3_mp_out_ch_6,  c3_mp_out_ch_5,  c3_mp_out_ch_4,
                   c3_mp_out_ch_3,  c3_mp_out_ch_2,  c3_mp_out_ch_1,  c3_mp_out_ch_0};
    assign wr_en = c3_mp_out_valid & ~full[wr_bank];
    assign drop  = c3_mp_out_valid & full[wr_bank];
    assign ld    = full[rd_bank] & (~s4_valid | s4_ready);
    assign hs    = s4_valid & s4_ready;
    // bank storage; contents are only meaningful once the bank is marked full
    always_ff @(posedge clk)
        if (wr_en) mem[wr_bank][wr_ptr] <= beat;
    // bank ownership: writer fills and marks full, reader frees a bank once its last beat is copied out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 5'd1;
                if (wr_ptr == LAST) begin
                    wr_bank       <= ~wr_bank;
                    full[wr_bank] <= 1'b1;
                end
            end
            if (ld) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 5'd1;
                if (rd_ptr == LAST) begin
                    rd_bank       <= ~rd_bank;
                    full[rd_bank] <= 1'b0;
                end
            end
        end
    end
    // output register: reload whenever empty or being consumed, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s4_valid      <= 1'b0;
            s4_data       <= '0;
            s4_pos        <= '0;
            s4_last       <= 1'b0;
            s4_frame_done <= 1'b0;
        end else begin
            if (ld) begin
                s4_valid <= 1'b1;
                s4_data  <= mem[rd_bank][rd_ptr];
                s4_pos   <= rd_ptr;
                s4_last  <= (rd_ptr == LAST);
            end else if (hs) begin
                s4_valid <= 1'b0;
            end
            s4_frame_done <= hs & s4_last;
        end
    end
    // saturating count of beats discarded because both banks were occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s4_overflow_cnt <= '0;
        else if (drop && !(&s4_overflow_cnt)) s4_overflow_cnt <= s4_overflow_cnt + OVF_W'(1);
    end
endmodule
